gate_test_sequencer: RTL
========================

Name: gate_test_sequencer

Overview:
- Synthesizable self-test controller for the 2-input XOR `gate` core, driving its `a`/`b` inputs and checking its `c` output.
- Waits for the core's `ready`, applies each stored vector, waits a programmable settle time, samples `c` and compares it against the expected value.
- Reports pass/fail, error count and first failing index; a cycle watchdog guards against a core that never asserts `ready`.
- Instantiated beside `gate` in the naive example top for on-fabric built-in self-test.

Parameters:
- N_TESTS, 4, number of vectors applied (1..4), taken from the package ROM in index order.
- SETTLE_CYCLES, 1, cycles operands are held before `c` is sampled (must be >=1).
- MAX_CYCLE, 100000, watchdog limit in cycles counted from start.
- CNT_W, 32, width of the watchdog counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- start  in  1  single-cycle run request; honoured only in IDLE or DONE
- dut_ready  in  1  `ready` from the gate core
- dut_c  in  1  `c` from the gate core
- dut_a  out  1  operand a to the core (registered)
- dut_b  out  1  operand b to the core (registered)
- busy  out  1  high from WAIT_RDY through CHECK
- done  out  1  high while in DONE
- pass  out  1  valid when done=1: err_count==0 and no timeout
- timeout  out  1  set when the watchdog fired in this run
- err_count  out  3  number of mismatches in this run
- first_fail_idx  out  2  index of the first mismatch; 0 if none

Behaviour:
- Reset: next edge puts the FSM in IDLE. All outputs reset to 0: dut_a, dut_b, busy, done, pass, timeout, err_count, first_fail_idx. Reset mid-run aborts the run with no residue.
- FSM states: IDLE, WAIT_RDY, SETTLE, CHECK, DONE.
- IDLE: on start, clear idx, err_count, first_fail_idx, timeout and the watchdog, then go to WAIT_RDY.
- WAIT_RDY: when dut_ready=1, load dut_a/dut_b from ROM[idx], load the settle counter with SETTLE_CYCLES, and go to SETTLE. Otherwise stay.
- SETTLE: decrement the settle counter. Go to CHECK after exactly SETTLE_CYCLES cycles in this state.
  - If dut_ready=0 in any SETTLE cycle, return to WAIT_RDY with idx unchanged (the vector is retried, nothing is counted).
- CHECK: compare dut_c against ROM[idx].c.
  - On mismatch: increment err_count (saturating at 7). If this is the first error, capture idx into first_fail_idx.
  - If idx==N_TESTS-1, go to DONE; else increment idx and go to WAIT_RDY.
- DONE: hold done, pass and the counters. start restarts the run exactly as from IDLE.
- start is ignored while busy=1.
- dut_a/dut_b change only on a vector load and otherwise hold their last value.
- Latency (dut_ready held high): start sampled at cycle 0 gives done=1 from cycle 1+N_TESTS*(SETTLE_CYCLES+2). Defaults: cycle 13.
- Watchdog:
  - Counts every cycle while busy.
  - When the count reaches MAX_CYCLE-1, set timeout=1 and go to DONE with pass=0.
  - If it fires in the same cycle as the final CHECK, the completion wins: the compare is counted and timeout stays 0.
  - In any other state the watchdog pre-empts the current transition.

Optional Feature:
- Macro GATE_SEQ_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE (pass=0, err_count=1, first_fail_idx=idx); the remaining vectors are skipped.
- Undefined: all N_TESTS vectors always run and every mismatch is counted.

Decomposition:
- Package gate_seq_pkg holds:
  - the state enum;
  - the vector struct {a, b, c};
  - the constant VEC_ROM[0:3] = {0,0,0}, {0,1,1}, {1,1,0}, {1,0,1};
  - the error-count width constant.
- One sub-module, gate_seq_watchdog: CNT_W counter with clear, enable and limit compare, producing a registered fire pulse.

Test Plan:
- Correct XOR model, ready tied high, start at cycle 0 -> done at cycle 13; pass=1; err_count=0; operand sequence ab = 00, 01, 11, 10.
- Model with c forced to 0 -> err_count=2, first_fail_idx=1, pass=0. With GATE_SEQ_STOP_ON_FAIL_EN defined -> done at cycle 7, err_count=1.
- ready held low, MAX_CYCLE=50 -> timeout=1, done=1, pass=0 at cycle 50; operands never loaded and stay 0.
- ready dropped for 1 cycle during SETTLE of vector 2 -> vector 2 reapplied, final pass=1, done delayed by the retry cycles.
- reset asserted while in SETTLE of vector 1 -> next cycle all outputs 0 and state IDLE; a new start then completes with pass=1.
- start pulsed while busy -> ignored; run completes normally at cycle 13.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate core self-test sequencer.
package gate_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StSettle,
        StCheck,
        StDone
    } state_e;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
    } vec_t;

    localparam int unsigned ERR_W = 3;

    localparam vec_t VEC_ROM [0:3] = '{3'b000, 3'b011, 3'b110, 3'b101};

endpackage

// File: rtl/gate_seq_watchdog.sv
// Cycle watchdog: counts enabled cycles since clear and raises a registered fire
// flag during the cycle in which the count equals MAX_CYCLE-1.
module gate_seq_watchdog #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned MAX_CYCLE = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic fire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLE - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             fire_d, fire_q;

    // The start cycle itself is cycle 0, so the first busy cycle already counts as 1.
    always_comb begin
        cnt_d  = cnt_q;
        fire_d = 1'b0;
        if (clr) begin
            cnt_d  = CNT_W'(1);
            fire_d = (cnt_d == LIMIT);
        end else if (en) begin
            cnt_d  = cnt_q + 1'b1;
            fire_d = (cnt_d == LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            fire_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fire_q <= fire_d;
        end
    end

    assign fire = fire_q;

endmodule

// File: rtl/gate_test_sequencer.sv
// Built-in self-test sequencer for the 2-input XOR gate core.
// Optional macro GATE_SEQ_STOP_ON_FAIL_EN: end the run at the first mismatch.
module gate_test_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned N_TESTS       = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned MAX_CYCLE     = 100000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_ready,
    input  logic             dut_c,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_idx
);

    localparam int unsigned      SET_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [1:0]       LAST_IDX = 2'(N_TESTS - 1);

    state_e           state_d, state_q;
    logic [1:0]       idx_d, idx_q, ffi_d, ffi_q;
    logic [ERR_W-1:0] err_d, err_q;
    logic [SET_W-1:0] set_d, set_q;
    logic             a_d, a_q, b_d, b_q, to_d, to_q;
    logic             wd_clr, wd_fire, mismatch, final_check;

    assign busy        = (state_q == StWaitRdy) || (state_q == StSettle) || (state_q == StCheck);
    assign mismatch    = (dut_c != VEC_ROM[idx_q].c);
    assign final_check = (state_q == StCheck) && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        set_d   = set_q;
        a_d     = a_q;
        b_d     = b_q;
        to_d    = to_q;
        wd_clr  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWaitRdy;
                    idx_d   = '0;
                    err_d   = '0;
                    ffi_d   = '0;
                    to_d    = 1'b0;
                    wd_clr  = 1'b1;
                end
            end
            StWaitRdy: begin
                if (dut_ready) begin
                    a_d     = VEC_ROM[idx_q].a;
                    b_d     = VEC_ROM[idx_q].b;
                    set_d   = SET_W'(SETTLE_CYCLES);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                set_d = set_q - 1'b1;
                if (!dut_ready) begin
                    state_d = StWaitRdy;
                end else if (set_q == SET_W'(1)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q == '0) ffi_d = idx_q;
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StWaitRdy;
                end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                if (mismatch) begin
                    idx_d   = idx_q;
                    state_d = StDone;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        // Watchdog overrides everything except completion of the last vector.
        if (wd_fire && busy && !final_check) begin
            state_d = StDone;
            idx_d   = idx_q;
            err_d   = err_q;
            ffi_d   = ffi_q;
            a_d     = a_q;
            b_d     = b_q;
            to_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            err_q   <= '0;
            ffi_q   <= '0;
            set_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            set_q   <= set_d;
            a_q     <= a_d;
            b_q     <= b_d;
            to_q    <= to_d;
        end
    end

    gate_seq_watchdog #(
        .CNT_W     (CNT_W),
        .MAX_CYCLE (MAX_CYCLE)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr   (wd_clr),
        .en    (busy),
        .fire  (wd_fire)
    );

    assign dut_a          = a_q;
    assign dut_b          = b_q;
    assign done           = (state_q == StDone);
    assign pass           = done && (err_q == '0) && !to_q;
    assign timeout        = to_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule
